// File: rtl/ram_io_pkg.sv
// Shared defaults, FSM/region types and helpers for the RAM + memory-mapped I/O controller.
package ram_io_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_DEPTH      = 64;
    localparam int unsigned DEF_IO_BASE    = 64;
    localparam int unsigned DEF_IO_OUT_NUM = 2;
    localparam int unsigned DEF_IO_IN_NUM  = 2;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO_OUT,
        REG_IO_IN,
        REG_NONE
    } region_e;

    // Index width for an array of n entries, never zero.
    function automatic int unsigned addr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_io_ctrl_if.sv
// Load/store request/response bus between the execute/write-back stage and ram_io_ctrl.
interface ram_io_ctrl_if
    import ram_io_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              RAM_REQ;
    logic              RAM_WEN;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_IN;
    logic [DATA_W-1:0] RAM_OUT;
    logic              RAM_ACK;
    logic              RAM_ERR;
    logic              RAM_BUSY;

    modport master (
        output RAM_REQ, RAM_WEN, RAM_ADDR, RAM_IN,
        input  RAM_OUT, RAM_ACK, RAM_ERR, RAM_BUSY
    );

    modport slave (
        input  RAM_REQ, RAM_WEN, RAM_ADDR, RAM_IN,
        output RAM_OUT, RAM_ACK, RAM_ERR, RAM_BUSY
    );
endinterface

// File: rtl/ram_io_core.sv
// Single-port synchronous RAM array with registered read; kept separate so a vendor macro can replace it.
module ram_io_core
    import ram_io_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned AW     = addr_bits(DEPTH)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves on a read so the controller can hold it across writes.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/ram_io_ctrl.sv
// Single-clock data RAM with a memory-mapped I/O window and registered, acknowledged responses.
// Optional post-reset RAM clear sequencer enabled by defining RAM_CLEAR_EN.
module ram_io_ctrl
    import ram_io_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned IO_BASE    = DEF_IO_BASE,
    parameter int unsigned IO_OUT_NUM = DEF_IO_OUT_NUM,
    parameter int unsigned IO_IN_NUM  = DEF_IO_IN_NUM
) (
    input  logic                         CLK,
    input  logic                         RST,
    ram_io_ctrl_if.slave                 bus,
    input  logic [IO_IN_NUM*DATA_W-1:0]  IO_IN,
    output logic [IO_OUT_NUM*DATA_W-1:0] IO_OUT
);
    localparam int unsigned AX_W   = ADDR_W + 1;
    localparam int unsigned RAM_AW = addr_bits(DEPTH);

    logic [AX_W-1:0]             addr_x;
    logic [IO_OUT_NUM-1:0]       out_hit;
    logic [IO_IN_NUM-1:0]        in_hit;
    region_e                     region;
    logic [DATA_W-1:0]           io_rd_val;
    logic [IO_IN_NUM*DATA_W-1:0] io_in_q;
    logic                        busy;
    logic                        acc;
    logic                        clr_we;
    logic [RAM_AW-1:0]           clr_addr;
    logic                        core_we;
    logic                        core_re;
    logic [RAM_AW-1:0]           core_addr;
    logic [DATA_W-1:0]           core_wdata;
    logic [DATA_W-1:0]           core_rdata;
    logic                        ack_q;
    logic                        err_q;
    logic                        ram_sel_q;
    logic [DATA_W-1:0]           io_data_q;

    // Zero-extended so region bounds compare over the full address with no wrap.
    assign addr_x = {1'b0, bus.RAM_ADDR};

    always_comb begin
        out_hit   = '0;
        in_hit    = '0;
        io_rd_val = '0;
        for (int k = 0; k < IO_OUT_NUM; k++) begin
            out_hit[k] = (addr_x == AX_W'(IO_BASE + k));
            if (out_hit[k]) io_rd_val = io_rd_val | IO_OUT[k*DATA_W +: DATA_W];
        end
        for (int k = 0; k < IO_IN_NUM; k++) begin
            in_hit[k] = (addr_x == AX_W'(IO_BASE + IO_OUT_NUM + k));
            if (in_hit[k]) io_rd_val = io_rd_val | io_in_q[k*DATA_W +: DATA_W];
        end
        if (addr_x < AX_W'(DEPTH))  region = REG_RAM;
        else if (|out_hit)          region = REG_IO_OUT;
        else if (|in_hit)           region = REG_IO_IN;
        else                        region = REG_NONE;
    end

`ifdef RAM_CLEAR_EN
    state_e            state;
    state_e            state_nx;
    logic [RAM_AW-1:0] cnt;
    logic [RAM_AW-1:0] cnt_nx;
    logic              busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            busy_q <= (state_nx == CLEAR);
        end
    end

    // One zero word per cycle until the last RAM word, then release the CPU.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we   = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt == RAM_AW'(DEPTH - 1)) state_nx = RUN;
                else                           cnt_nx   = cnt + RAM_AW'(1);
            end
            RUN:     ;
            default: state_nx = CLEAR;
        endcase
    end

    assign clr_addr = cnt;
    assign busy     = busy_q;
`else
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
    assign busy     = 1'b0;
`endif

    assign acc        = bus.RAM_REQ && !busy;
    assign core_we    = !RST && (clr_we || (acc && bus.RAM_WEN && region == REG_RAM));
    assign core_re    = !RST && acc && !bus.RAM_WEN && region == REG_RAM;
    assign core_addr  = clr_we ? clr_addr : bus.RAM_ADDR[RAM_AW-1:0];
    assign core_wdata = clr_we ? '0 : bus.RAM_IN;

    ram_io_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_core (
        .CLK   (CLK),
        .we    (core_we),
        .re    (core_re),
        .addr  (core_addr),
        .wdata (core_wdata),
        .rdata (core_rdata)
    );

    always_ff @(posedge CLK) begin
        io_in_q <= IO_IN;
    end

    // Response registers; RAM_OUT keeps the last read source so writes leave it unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ram_sel_q <= 1'b0;
            io_data_q <= '0;
            IO_OUT    <= '0;
        end else begin
            ack_q <= acc;
            err_q <= acc && ((region == REG_NONE) || (region == REG_IO_IN && bus.RAM_WEN));
            if (acc && !bus.RAM_WEN) begin
                ram_sel_q <= (region == REG_RAM);
                io_data_q <= io_rd_val;
            end
            if (acc && bus.RAM_WEN) begin
                for (int k = 0; k < IO_OUT_NUM; k++) begin
                    if (out_hit[k]) IO_OUT[k*DATA_W +: DATA_W] <= bus.RAM_IN;
                end
            end
        end
    end

    assign bus.RAM_OUT  = ram_sel_q ? core_rdata : io_data_q;
    assign bus.RAM_ACK  = ack_q;
    assign bus.RAM_ERR  = err_q;
    assign bus.RAM_BUSY = busy;
endmodule
